// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: bus widths, the OAM DMA trigger address and
// the DMA sequencer state encoding.
package nes_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] DMA_REG_ADDR_DEFAULT = 16'h4014;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    ALIGN = 3'd2,
    RD    = 3'd3,
    WR    = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Memory-port arbiter between the 6502 core and the OAM sprite-DMA engine.
// CPU traffic passes straight through until a write to the DMA register
// stalls the CPU and copies one 256-byte page into sprite OAM.
//
//   state | meaning
//   IDLE  | CPU owns the memory port, combinational pass-through
//   ACK   | completes the trigger write (one-cycle cpu_rdy)
//   ALIGN | dummy cycles before the first DMA read
//   RD    | reading {page, cnt} from memory, waiting for mem_rdy
//   WR    | writing the fetched byte to OAM[cnt]
module oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
  parameter int unsigned       ALIGN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic              cpu_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [7:0]        oam_addr,
  output logic [DATA_W-1:0] oam_data,
  output logic              oam_wen,
  output logic              dma_busy
);

  // Align counter is a down-counter: load N-1 on entry, leave ALIGN at zero.
  localparam logic [1:0] ALIGN_LOAD = (ALIGN_CYCLES > 0) ? 2'(ALIGN_CYCLES - 1) : 2'd0;

  dma_state_t        state_q, state_d;
  logic [7:0]        page_q, page_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [1:0]        align_q, align_d;
  logic              dma_trig;

  assign dma_trig = cpu_wen && (cpu_addr == DMA_REG_ADDR);
  assign dma_busy = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    align_d      = align_q;
    cpu_data_in  = '0;
    cpu_rdy      = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    oam_addr     = '0;
    oam_data     = '0;
    oam_wen      = 1'b0;

    unique case (state_q)
      IDLE: begin
        mem_addr     = cpu_addr;
        mem_data_out = cpu_data_out;
        mem_ren      = cpu_ren;
        mem_wen      = cpu_wen;
        cpu_rdy      = mem_rdy;
        cpu_data_in  = mem_data_in;
        if (dma_trig) begin
          mem_wen = 1'b0;
          page_d  = cpu_data_out;
          cnt_d   = '0;
          state_d = ACK;
        end
      end

      ACK: begin
        cpu_rdy = 1'b1;
        if (ALIGN_CYCLES > 0) begin
          align_d = ALIGN_LOAD;
          state_d = ALIGN;
        end else begin
          state_d = RD;
        end
      end

      ALIGN: begin
        if (align_q == 2'd0) begin
          state_d = RD;
        end else begin
          align_d = align_q - 2'd1;
        end
      end

      RD: begin
        mem_ren  = 1'b1;
        mem_addr = {page_q, cnt_q};
        if (mem_rdy) begin
          byte_d  = mem_data_in;
          state_d = WR;
        end
      end

      WR: begin
        oam_wen  = 1'b1;
        oam_addr = cnt_q;
        oam_data = byte_q;
        // Last byte is decided on the pre-increment value; cnt simply wraps.
        cnt_d    = cnt_q + 8'd1;
        state_d  = (cnt_q == 8'hFF) ? IDLE : RD;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      align_q <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      align_q <= align_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: fixed-latency memory model, a
// per-cycle schedule model of the DMA, and directed CPU transactions.
module tb_oam_dma_arbiter;

  localparam int ALIGN = 1;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_ren, cpu_wen;
  logic [7:0]  cpu_data_in;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_ren, mem_wen;
  logic        mem_rdy;
  logic [7:0]  mem_data_in;
  logic [7:0]  oam_addr, oam_data;
  logic        oam_wen;
  logic        dma_busy;

  oam_dma_arbiter #(.DMA_REG_ADDR(16'h4014), .ALIGN_CYCLES(ALIGN)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
    .cpu_data_in(cpu_data_in), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_rdy(mem_rdy), .mem_data_in(mem_data_in),
    .oam_addr(oam_addr), .oam_data(oam_data), .oam_wen(oam_wen),
    .dma_busy(dma_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int lat;
  int cyc;

  // memory side bookkeeping (written only by the memory process)
  logic [15:0] last_wr_addr;
  logic [7:0]  last_wr_data;
  int          n_wr;

  // monitor bookkeeping (written only by the monitor process)
  int          busy_run, last_busy_len, oam_cnt;
  logic        got_rd, got_oam;
  logic [15:0] first_rd;
  logic [7:0]  first_oam;
  logic [7:0]  oam_img [256];

  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'h0123) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory: acknowledges a held request in its lat-th cycle.
  initial begin
    int wc;
    wc = 0;
    mem_rdy = 1'b0;
    mem_data_in = 8'h00;
    n_wr = 0;
    last_wr_addr = 16'h0;
    last_wr_data = 8'h0;
    forever begin
      @(negedge clk);
      if (mem_ren || mem_wen) begin
        wc++;
        if (wc >= lat) begin
          mem_rdy = 1'b1;
          mem_data_in = pat(mem_addr);
          if (mem_wen) begin
            last_wr_addr = mem_addr;
            last_wr_data = mem_data_out;
            n_wr++;
          end
          wc = 0;
        end else begin
          mem_rdy = 1'b0;
        end
      end else begin
        wc = 0;
        mem_rdy = 1'b0;
      end
    end
  end

  // Schedule model: IDLE is pure pass-through; after a trigger at cycle t,
  // cycle t+k is ACK (k=1), ALIGN, then bytes of (lat+1) cycles each.
  initial begin
    logic        act;
    logic        trig;
    int          t, k, j, b, total;
    logic [7:0]  pg, bb;
    logic        exp_ren, exp_oam;
    act = 1'b0;
    t = 0;
    pg = 8'h0;
    cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst) act = 1'b0;
      if (!act) begin
        trig = rst && cpu_wen && (cpu_addr == 16'h4014);
        chk("pt_mem_addr", mem_addr, cpu_addr);
        chk("pt_mem_data_out", mem_data_out, cpu_data_out);
        chk("pt_mem_ren", mem_ren, cpu_ren);
        chk("pt_mem_wen", mem_wen, cpu_wen && !trig);
        chk("pt_cpu_rdy", cpu_rdy, mem_rdy);
        chk("pt_cpu_data_in", cpu_data_in, mem_data_in);
        chk("idle_oam_wen", oam_wen, 0);
        chk("idle_dma_busy", dma_busy, 0);
        if (trig) begin
          act = 1'b1;
          t = cyc;
          pg = cpu_data_out;
        end
      end else begin
        k = cyc - t;
        total = 1 + ALIGN + 256 * (lat + 1);
        exp_ren = 1'b0;
        exp_oam = 1'b0;
        bb = 8'h0;
        if (k >= 2 + ALIGN) begin
          j = k - 2 - ALIGN;
          b = j / (lat + 1);
          bb = 8'(b);
          if ((j % (lat + 1)) < lat) exp_ren = 1'b1;
          else exp_oam = 1'b1;
        end
        chk("dma_busy", dma_busy, 1);
        chk("dma_cpu_rdy", cpu_rdy, k == 1);
        chk("dma_mem_ren", mem_ren, exp_ren);
        chk("dma_mem_wen", mem_wen, 0);
        chk("dma_oam_wen", oam_wen, exp_oam);
        if (exp_ren) chk("dma_mem_addr", mem_addr, {pg, bb});
        if (k == 1) begin
          chk("ack_mem_addr", mem_addr, 0);
          chk("ack_mem_data_out", mem_data_out, 0);
        end
        if (exp_oam) begin
          chk("dma_oam_addr", oam_addr, bb);
          chk("dma_oam_data", oam_data, pat({pg, bb}));
        end
        if (k >= total) act = 1'b0;
      end
    end
  end

  // Monitor: busy run length, first read / first OAM index, OAM image.
  initial begin
    busy_run = 0;
    last_busy_len = 0;
    oam_cnt = 0;
    got_rd = 1'b0;
    got_oam = 1'b0;
    first_rd = 16'h0;
    first_oam = 8'h0;
    forever begin
      @(negedge clk);
      #3;
      if (dma_busy) begin
        if (busy_run == 0) begin
          got_rd = 1'b0;
          got_oam = 1'b0;
        end
        busy_run++;
        if (mem_ren && !got_rd) begin
          first_rd = mem_addr;
          got_rd = 1'b1;
        end
        if (oam_wen) begin
          if (!got_oam) first_oam = oam_addr;
          got_oam = 1'b1;
          oam_img[oam_addr] = oam_data;
          oam_cnt++;
        end
      end else if (busy_run > 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completing cycle.
  task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output int waited, output logic busy_at);
    cpu_addr = a;
    cpu_data_out = d;
    cpu_ren = !wr;
    cpu_wen = wr;
    waited = 0;
    rd = 8'h0;
    busy_at = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #4;
      waited++;
      if (cpu_rdy) begin
        rd = cpu_data_in;
        busy_at = dma_busy;
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #4;
      if (!dma_busy) break;
    end
    chk("idle_within_budget", dma_busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_image(input logic [7:0] pg, input int base);
    logic [7:0] idx;
    chk("oam_write_count", oam_cnt - base, 256);
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      chk("oam_image", oam_img[i], pat({pg, idx}));
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         waited, base;
    logic       busy_at;
    n_chk = 0;
    n_pass = 0;
    lat = 1;
    rst = 1'b0;
    cpu_addr = 16'h1234;
    cpu_data_out = 8'h00;
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;

    #12;
    chk("rst_oam_wen", oam_wen, 0);
    chk("rst_oam_addr", oam_addr, 0);
    chk("rst_oam_data", oam_data, 0);
    chk("rst_dma_busy", dma_busy, 0);
    chk("rst_mem_addr_follows", mem_addr, 16'h1234);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // pass-through read
    cpu_access(1'b0, 16'h0123, 8'h00, rd, waited, busy_at);
    chk("pt_read_data", rd, 8'h5A);
    chk("pt_read_latency", waited, 1);
    chk("pt_read_busy", busy_at, 0);

    // non-trigger accesses
    cpu_access(1'b0, 16'h4014, 8'h00, rd, waited, busy_at);
    chk("read_4014_data", rd, 8'h68);
    chk("read_4014_busy", busy_at, 0);
    cpu_access(1'b1, 16'h4015, 8'h77, rd, waited, busy_at);
    chk("write_4015_latency", waited, 1);
    chk("write_4015_addr", last_wr_addr, 16'h4015);
    chk("write_4015_data", last_wr_data, 8'h77);
    chk("nontrig_no_dma", last_busy_len, 0);

    // trigger page 02, CPU read held from the first ALIGN cycle
    base = oam_cnt;
    cpu_access(1'b1, 16'h4014, 8'h02, rd, waited, busy_at);
    chk("trig_ack_cycle", waited, 2);
    chk("trig_ack_busy", busy_at, 1);
    chk("trig_not_forwarded", n_wr, 1);
    cpu_access(1'b0, 16'h8000, 8'h00, rd, waited, busy_at);
    chk("stall_read_data", rd, 8'hBC);
    chk("stall_read_wait", waited, 514);
    chk("stall_read_busy", busy_at, 0);
    chk("busy_len_l1", last_busy_len, 514);
    chk("first_rd_page02", first_rd, 16'h0200);
    chk("first_oam_idx", first_oam, 0);
    chk("oam_last_byte", oam_img[255], 8'hC1);
    check_image(8'h02, base);

    // wait states: L=3
    lat = 3;
    base = oam_cnt;
    cpu_access(1'b1, 16'h4014, 8'h05, rd, waited, busy_at);
    chk("trig5_ack_cycle", waited, 2);
    wait_idle();
    chk("busy_len_l3", last_busy_len, 1026);
    chk("first_rd_page05", first_rd, 16'h0500);
    check_image(8'h05, base);

    // reset in the middle of a DMA
    lat = 1;
    base = oam_cnt;
    cpu_access(1'b1, 16'h4014, 8'h03, rd, waited, busy_at);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #4;
      if (oam_cnt - base >= 100) break;
    end
    chk("reached_byte_100", oam_cnt - base, 100);
    rst = 1'b0;
    #1;
    chk("arst_dma_busy", dma_busy, 0);
    chk("arst_oam_wen", oam_wen, 0);
    chk("arst_oam_addr", oam_addr, 0);
    chk("arst_oam_data", oam_data, 0);
    chk("arst_mem_ren", mem_ren, 0);
    repeat (3) @(negedge clk);
    #4;
    chk("no_oam_after_reset", oam_cnt - base, 100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    base = oam_cnt;
    cpu_access(1'b1, 16'h4014, 8'h04, rd, waited, busy_at);
    chk("retrig_ack_cycle", waited, 2);
    wait_idle();
    chk("retrig_first_oam", first_oam, 0);
    chk("retrig_first_rd", first_rd, 16'h0400);
    chk("retrig_busy_len", last_busy_len, 514);
    chk("retrig_byte_100", oam_img[100], 8'h5C);
    check_image(8'h04, base);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
